wb_port_arbiter: RTL and testbench

Shares the single LC3 register-file write port between the execute requester (aluout/pcout results) and the memory requester (memout load data). It selects the writeback source using W_control encoding, buffers one displaced execute result, prevents execute starvation with a bounded counter, and registers the write command and NZP condition codes. It sits between the execute/memory stages and the register file, inside the writeback stage.

---
 rtl/wb_port_arbiter.sv | 172 +++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Writeback-port arbiter: shares the single register-file write port between execute and memory results.
// Optional WB_BYPASS_EN macro forwards the registered write data onto the read-port outputs.
module wb_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_writeback,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [2:0]  ex_dr,
  input  logic [1:0]  ex_W_control,
  input  logic [15:0] ex_aluout,
  input  logic [15:0] ex_pcout,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [2:0]  mem_dr,
  input  logic [15:0] memout,
  output logic        rf_we,
  output logic [2:0]  rf_dr,
  output logic [15:0] rf_data,
  output logic [2:0]  psr,
  output logic        err_illegal,
  input  logic [2:0]  sr1,
  input  logic [2:0]  sr2,
  input  logic [15:0] rf_rd1,
  input  logic [15:0] rf_rd2,
  output logic [15:0] vsr1,
  output logic [15:0] vsr2
);

  localparam int unsigned DW = 16;
  localparam int unsigned RW = 3;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
  localparam logic [2:0] PSR_RST = 3'b010;

  logic          r_rf_we;
  logic [RW-1:0] r_rf_dr;
  logic [DW-1:0] r_rf_data;
  logic [2:0]    r_psr;
  logic          r_err;
  logic          r_pend_full;
  logic [RW-1:0] r_pend_dr;
  logic [DW-1:0] r_pend_data;
  logic [CW-1:0] r_starve_cnt;

  logic          w_preempt;
  logic          w_ex_ready;
  logic          w_mem_ready;
  logic          w_ex_xfer;
  logic          w_mem_xfer;
  logic          w_ex_legal;
  logic [DW-1:0] w_ex_data;

  logic          w_we_n;
  logic [RW-1:0] w_dr_n;
  logic [DW-1:0] w_data_n;
  logic [2:0]    w_psr_n;
  logic          w_err_n;
  logic          w_pend_full_n;
  logic [RW-1:0] w_pend_dr_n;
  logic [DW-1:0] w_pend_data_n;
  logic [CW-1:0] w_starve_n;

  // Handshake: pending entry blocks execute; a starved entry blocks memory.
  assign w_preempt   = r_pend_full && (r_starve_cnt == LIMIT);
  assign w_ex_ready  = reset && enable_writeback && !r_pend_full;
  assign w_mem_ready = reset && enable_writeback && !w_preempt;
  assign w_ex_xfer   = ex_valid && w_ex_ready;
  assign w_mem_xfer  = mem_valid && w_mem_ready;
  assign w_ex_legal  = (ex_W_control == 2'd0) || (ex_W_control == 2'd2);
  assign w_ex_data   = ex_W_control[1] ? ex_pcout : ex_aluout;

  assign ex_ready    = w_ex_ready;
  assign mem_ready   = w_mem_ready;

  // Next-state: writeback source priority, pending buffer and starvation counter.
  always_comb begin
    w_we_n        = 1'b0;
    w_dr_n        = r_rf_dr;
    w_data_n      = r_rf_data;
    w_psr_n       = r_psr;
    w_err_n       = r_err;
    w_pend_full_n = r_pend_full;
    w_pend_dr_n   = r_pend_dr;
    w_pend_data_n = r_pend_data;
    w_starve_n    = r_starve_cnt;

    if (enable_writeback) begin
      w_err_n = r_err | (w_ex_xfer && !w_ex_legal);

      if (w_preempt) begin
        w_we_n        = 1'b1;
        w_dr_n        = r_pend_dr;
        w_data_n      = r_pend_data;
        w_pend_full_n = 1'b0;
      end else if (w_mem_xfer) begin
        w_we_n   = 1'b1;
        w_dr_n   = mem_dr;
        w_data_n = memout;
        if (w_ex_xfer && w_ex_legal) begin
          w_pend_full_n = 1'b1;
          w_pend_dr_n   = ex_dr;
          w_pend_data_n = w_ex_data;
        end
      end else if (r_pend_full) begin
        w_we_n        = 1'b1;
        w_dr_n        = r_pend_dr;
        w_data_n      = r_pend_data;
        w_pend_full_n = 1'b0;
      end else if (w_ex_xfer && w_ex_legal) begin
        w_we_n   = 1'b1;
        w_dr_n   = ex_dr;
        w_data_n = w_ex_data;
      end

      if (!w_pend_full_n) begin
        w_starve_n = '0;
      end else if (r_pend_full && (r_starve_cnt != LIMIT)) begin
        w_starve_n = r_starve_cnt + CW'(1);
      end
    end

    if (w_we_n) begin
      w_psr_n = {w_data_n[DW-1], (w_data_n == '0), !w_data_n[DW-1] && (w_data_n != '0)};
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_rf_we      <= 1'b0;
      r_rf_dr      <= '0;
      r_rf_data    <= '0;
      r_psr        <= PSR_RST;
      r_err        <= 1'b0;
      r_pend_full  <= 1'b0;
      r_pend_dr    <= '0;
      r_pend_data  <= '0;
      r_starve_cnt <= '0;
    end else begin
      r_rf_we      <= w_we_n;
      r_rf_dr      <= w_dr_n;
      r_rf_data    <= w_data_n;
      r_psr        <= w_psr_n;
      r_err        <= w_err_n;
      r_pend_full  <= w_pend_full_n;
      r_pend_dr    <= w_pend_dr_n;
      r_pend_data  <= w_pend_data_n;
      r_starve_cnt <= w_starve_n;
    end
  end

  assign rf_we       = r_rf_we;
  assign rf_dr       = r_rf_dr;
  assign rf_data     = r_rf_data;
  assign psr         = r_psr;
  assign err_illegal = r_err;

`ifdef WB_BYPASS_EN
  // Forward the write in flight so readers see it in the same cycle.
  assign vsr1 = (r_rf_we && (r_rf_dr == sr1)) ? r_rf_data : rf_rd1;
  assign vsr2 = (r_rf_we && (r_rf_dr == sr2)) ? r_rf_data : rf_rd2;
`else
  logic w_unused_sr;
  assign w_unused_sr = ^{sr1, sr2};
  assign vsr1 = rf_rd1;
  assign vsr2 = rf_rd2;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed scoreboard bench for wb_port_arbiter (STARVE_LIMIT=4).
module tb_wb_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable_writeback;
  logic        ex_valid;
  logic        ex_ready;
  logic [2:0]  ex_dr;
  logic [1:0]  ex_W_control;
  logic [15:0] ex_aluout;
  logic [15:0] ex_pcout;
  logic        mem_valid;
  logic        mem_ready;
  logic [2:0]  mem_dr;
  logic [15:0] memout;
  logic        rf_we;
  logic [2:0]  rf_dr;
  logic [15:0] rf_data;
  logic [2:0]  psr;
  logic        err_illegal;
  logic [2:0]  sr1;
  logic [2:0]  sr2;
  logic [15:0] rf_rd1;
  logic [15:0] rf_rd2;
  logic [15:0] vsr1;
  logic [15:0] vsr2;

  typedef struct {
    logic [2:0]  dr;
    logic [15:0] data;
  } wr_t;

  wr_t        q[$];
  logic [2:0] exp_psr = 3'b010;
  int         vectors = 0;
  int         errs    = 0;

  wb_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clock(clock), .reset(reset), .enable_writeback(enable_writeback),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_dr(ex_dr),
    .ex_W_control(ex_W_control), .ex_aluout(ex_aluout), .ex_pcout(ex_pcout),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dr(mem_dr), .memout(memout),
    .rf_we(rf_we), .rf_dr(rf_dr), .rf_data(rf_data), .psr(psr),
    .err_illegal(err_illegal), .sr1(sr1), .sr2(sr2), .rf_rd1(rf_rd1),
    .rf_rd2(rf_rd2), .vsr1(vsr1), .vsr2(vsr2)
  );

  always #5 clock = ~clock;

  function automatic logic [2:0] psr_of(input logic [15:0] d);
    logic n;
    logic z;
    n = d[15];
    z = (d == 16'h0000);
    return {n, z, !n && !z};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] dr, input logic [15:0] data);
    wr_t e;
    e.dr   = dr;
    e.data = data;
    q.push_back(e);
  endtask

  // Advance one edge, then compare the write port against the scoreboard.
  task automatic step(input logic exp_we);
    wr_t e;
    @(posedge clock);
    #1;
    chk("rf_we", 16'(rf_we), 16'(exp_we));
    if (exp_we) begin
      chk("sb_has_entry", 16'(q.size() != 0), 16'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("rf_dr", 16'(rf_dr), 16'(e.dr));
        chk("rf_data", rf_data, e.data);
        exp_psr = psr_of(e.data);
      end
    end
    chk("psr", 16'(psr), 16'(exp_psr));
  endtask

  initial begin
    reset = 1'b0; enable_writeback = 1'b1;
    ex_valid = 1'b0; ex_dr = '0; ex_W_control = '0; ex_aluout = '0; ex_pcout = '0;
    mem_valid = 1'b0; mem_dr = '0; memout = '0;
    sr1 = '0; sr2 = '0; rf_rd1 = '0; rf_rd2 = '0;

    // Reset values
    step(1'b0);
    step(1'b0);
    chk("rst_rf_dr", 16'(rf_dr), 16'd0);
    chk("rst_rf_data", rf_data, 16'h0000);
    chk("rst_err", 16'(err_illegal), 16'd0);
    chk("rst_ex_ready", 16'(ex_ready), 16'd0);
    chk("rst_mem_ready", 16'(mem_ready), 16'd0);
    reset = 1'b1;
    #1;
    chk("ex_ready_idle", 16'(ex_ready), 16'd1);
    chk("mem_ready_idle", 16'(mem_ready), 16'd1);

    // Single execute aluout write, negative result
    ex_valid = 1'b1; ex_W_control = 2'd0; ex_aluout = 16'h8001; ex_pcout = 16'h1234; ex_dr = 3'd3;
    push(3'd3, 16'h8001);
    step(1'b1);
    ex_valid = 1'b0;
    step(1'b0);

    // Collision: memory writes first, execute pcout buffered
    mem_valid = 1'b1; mem_dr = 3'd2; memout = 16'h0000;
    ex_valid = 1'b1; ex_W_control = 2'd2; ex_pcout = 16'h0040; ex_aluout = 16'hDEAD; ex_dr = 3'd5;
    push(3'd2, 16'h0000);
    step(1'b1);
    mem_valid = 1'b0; ex_valid = 1'b0;
    chk("coll_ex_ready", 16'(ex_ready), 16'd0);
    chk("coll_mem_ready", 16'(mem_ready), 16'd1);
    push(3'd5, 16'h0040);
    step(1'b1);
    chk("drain_ex_ready", 16'(ex_ready), 16'd1);

    // Starvation: continuous memory traffic against a pending entry
    mem_valid = 1'b1; mem_dr = 3'd1; memout = 16'h1111;
    ex_valid = 1'b1; ex_W_control = 2'd0; ex_aluout = 16'h7FFF; ex_dr = 3'd6;
    push(3'd1, 16'h1111);
    step(1'b1);
    ex_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      memout = 16'hF000 + 16'(i);
      chk("starve_mem_ready", 16'(mem_ready), 16'd1);
      chk("starve_ex_ready", 16'(ex_ready), 16'd0);
      push(3'd1, memout);
      step(1'b1);
    end
    memout = 16'h0A0A;
    chk("preempt_mem_ready", 16'(mem_ready), 16'd0);
    push(3'd6, 16'h7FFF);
    step(1'b1);
    chk("resume_mem_ready", 16'(mem_ready), 16'd1);
    push(3'd1, 16'h0A0A);
    step(1'b1);
    mem_valid = 1'b0;
    step(1'b0);

    // Illegal W_control is consumed without a write and sets a sticky error
    ex_valid = 1'b1; ex_W_control = 2'd3; ex_aluout = 16'h5555; ex_pcout = 16'h6666; ex_dr = 3'd7;
    step(1'b0);
    ex_valid = 1'b0;
    chk("err_set", 16'(err_illegal), 16'd1);
    ex_valid = 1'b1; ex_W_control = 2'd0; ex_aluout = 16'h0000; ex_dr = 3'd0;
    push(3'd0, 16'h0000);
    step(1'b1);
    ex_valid = 1'b0;
    chk("err_sticky", 16'(err_illegal), 16'd1);

    // Disable with a pending entry: nothing moves until re-enable
    mem_valid = 1'b1; mem_dr = 3'd3; memout = 16'hFFFF;
    ex_valid = 1'b1; ex_W_control = 2'd2; ex_pcout = 16'h0002; ex_dr = 3'd4;
    push(3'd3, 16'hFFFF);
    step(1'b1);
    mem_valid = 1'b0;
    enable_writeback = 1'b0;
    ex_W_control = 2'd0; ex_aluout = 16'h0005; ex_dr = 3'd5;
    #1;
    chk("dis_ex_ready", 16'(ex_ready), 16'd0);
    chk("dis_mem_ready", 16'(mem_ready), 16'd0);
    step(1'b0);
    step(1'b0);
    enable_writeback = 1'b1;
    push(3'd4, 16'h0002);
    step(1'b1);
    push(3'd5, 16'h0005);
    step(1'b1);
    ex_valid = 1'b0;
    step(1'b0);

    // Reset while an entry is pending discards it
    mem_valid = 1'b1; mem_dr = 3'd1; memout = 16'h0001;
    ex_valid = 1'b1; ex_W_control = 2'd0; ex_aluout = 16'h0A0A; ex_dr = 3'd2;
    push(3'd1, 16'h0001);
    step(1'b1);
    mem_valid = 1'b0; ex_valid = 1'b0;
    reset = 1'b0;
    exp_psr = 3'b010;
    #1;
    chk("rst_low_ex_ready", 16'(ex_ready), 16'd0);
    step(1'b0);
    chk("midrst_rf_dr", 16'(rf_dr), 16'd0);
    chk("midrst_rf_data", rf_data, 16'h0000);
    reset = 1'b1;
    step(1'b0);
    step(1'b0);
    chk("post_rst_ex_ready", 16'(ex_ready), 16'd1);

    // Read-port outputs with and without the bypass
    ex_valid = 1'b1; ex_W_control = 2'd0; ex_aluout = 16'hBEEF; ex_dr = 3'd4;
    sr1 = 3'd4; sr2 = 3'd5; rf_rd1 = 16'h1111; rf_rd2 = 16'h2222;
    push(3'd4, 16'hBEEF);
    step(1'b1);
    ex_valid = 1'b0;
`ifdef WB_BYPASS_EN
    chk("vsr1_bypass", vsr1, 16'hBEEF);
`else
    chk("vsr1_raw", vsr1, 16'h1111);
`endif
    chk("vsr2_nomatch", vsr2, 16'h2222);
    step(1'b0);
    chk("vsr1_idle", vsr1, 16'h1111);

    chk("sb_drained", 16'(q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
